// File: rtl/fifo_pkg.sv
// Shared definitions for the team's asymmetric FIFOs (this 32-to-4 unpacking
// FIFO and its 4-to-32 packing counterpart).
//
// Contents:
//   DEPTH, RD_W, WR_W, NIB - geometry constants
//   AW, CW                 - slot address width and nibble column width
//   nib_t, word_t, col_t   - data and column types
//   flush_st_e             - flush controller states
//   get_nib()              - extract one narrow lane from a wide word
package fifo_pkg;

  localparam int DEPTH = 4;
  localparam int RD_W  = 4;
  localparam int WR_W  = 32;
  localparam int NIB   = WR_W / RD_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(NIB);

  typedef logic [RD_W-1:0] nib_t;
  typedef logic [WR_W-1:0] word_t;
  typedef logic [CW-1:0]   col_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_st_e;

  // Lane 0 occupies the least significant bits and leaves the FIFO first.
  function automatic nib_t get_nib(input word_t w, input col_t c);
    return w[RD_W*c +: RD_W];
  endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Wrap-bit pointer pair for a DEPTH-slot FIFO.
//
// The extra MSB on each pointer tells a full FIFO apart from an empty one
// when the slot indices coincide; pointers therefore wrap modulo 2*DEPTH.
//
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   wr_inc    - advance the write pointer (one word stored)
//   rd_inc    - advance the read pointer (one word popped or discarded)
//   wr_ptr    - write pointer, AW+1 bits
//   rd_ptr    - read pointer, AW+1 bits
//   count     - occupied slots, 0..DEPTH
//   full      - all slots occupied
//   empty     - no slots occupied
module fifo_ptr_ctl
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_inc,
  input  logic        rd_inc,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Both pointers move independently; a write and a pop in the same cycle
  // simply advance both, leaving the occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_inc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_inc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy is the modular pointer difference, so it stays correct across
  // the wrap without any special casing.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (count == FULL_CNT);
    empty = (count == '0);
  end

endmodule

// File: rtl/fifo_unpack_32to4.sv
// Wide-to-narrow FIFO: accepts 32-bit words (with 1..8 valid nibbles each)
// and hands them out one nibble at a time, first-word-fall-through.
// A held flush request discards every word present when it was raised while
// later writes keep flowing in.
//
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   wr           - write strobe, word taken when wr && !full
//   wr_data      - write word, nibble 0 = bits [3:0] leaves first
//   wr_nib       - valid nibbles in wr_data minus one
//   full, empty  - occupancy flags
//   vld_rd_data  - rd_data holds a readable nibble
//   rd           - read strobe, only while vld_rd_data is high
//   rd_data      - head nibble (zero when nothing is readable)
//   rd_last      - rd_data is the final valid nibble of its word
//   count        - occupied word slots, 0..DEPTH
//   flush_req    - flush request, held until flush_done is seen
//   flush_done   - single-cycle flush completion pulse
module fifo_unpack_32to4
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_nib,
  output logic        full,
  output logic        empty,
  output logic        vld_rd_data,
  input  logic        rd,
  output logic [3:0]  rd_data,
  output logic        rd_last,
  output logic [AW:0] count,
  input  logic        flush_req,
  output logic        flush_done
);

  word_t       mem [DEPTH];
  col_t        len [DEPTH];
  col_t        rd_col;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] tgt;
  flush_st_e   state;
  flush_st_e   state_nxt;

  logic          wr_acc;
  logic          rd_fire;
  logic          pop;
  logic          discard;
  logic          rd_inc;
  logic          at_tgt;
  logic [AW-1:0] wr_slot;
  logic [AW-1:0] rd_slot;

  assign wr_acc  = wr && !full;
  assign wr_slot = wr_ptr[AW-1:0];
  assign rd_slot = rd_ptr[AW-1:0];
  assign rd_inc  = pop || discard;

  fifo_ptr_ctl u_ptr (
    .clk    (clk),
    .rst    (rst),
    .wr_inc (wr_acc),
    .rd_inc (rd_inc),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Word storage. The length field travels with its word so the read side
  // knows where each word ends without any extra bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        len[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[wr_slot] <= wr_data;
      len[wr_slot] <= wr_nib;
    end
  end

  // Head-of-queue view. Reading is blocked while a flush is in progress, and
  // the data/last outputs are held at zero whenever nothing is readable so
  // the consumer never sees stale slot contents.
  always_comb begin
    vld_rd_data = !empty && (state == IDLE);
    rd_data     = '0;
    rd_last     = 1'b0;
    if (vld_rd_data) begin
      rd_data = get_nib(mem[rd_slot], rd_col);
      rd_last = (rd_col == len[rd_slot]);
    end
    rd_fire = rd && vld_rd_data;
    pop     = rd_fire && rd_last;
  end

  // Flush controller next-state logic. In FLUSH one word is thrown away per
  // cycle until the read pointer reaches the target captured at request
  // time; the completion pulse is raised on the cycle the target is reached.
  always_comb begin
    state_nxt  = state;
    discard    = 1'b0;
    flush_done = 1'b0;
    at_tgt     = (rd_ptr == tgt);
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (at_tgt) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          discard = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush state register and target capture. The target includes a word
  // accepted in the very cycle the request arrives, so that word is flushed
  // too; anything written later lies at or beyond the target and survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && flush_req) begin
        tgt <= wr_ptr + {{AW{1'b0}}, wr_acc};
      end
    end
  end

  // Nibble column within the head word. Any word leaving the head, whether
  // read out completely or discarded by a flush, restarts the column at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_col <= '0;
    end else if (pop || discard) begin
      rd_col <= '0;
    end else if (rd_fire) begin
      rd_col <= rd_col + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_unpack_32to4.sv
// Self-checking bench for fifo_unpack_32to4. A queue-of-words model predicts
// every output each cycle; directed sequences add literal expectations.
module tb_fifo_unpack_32to4;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [31:0] wr_data;
  logic [2:0]  wr_nib;
  logic        full;
  logic        empty;
  logic        vld_rd_data;
  logic        rd;
  logic [3:0]  rd_data;
  logic        rd_last;
  logic [2:0]  count;
  logic        flush_req;
  logic        flush_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          len;
  } mword_t;

  mword_t mq[$];
  int     mcol;
  bit     mflush;
  int     mleft;

  fifo_unpack_32to4 dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .wr_data     (wr_data),
    .wr_nib      (wr_nib),
    .full        (full),
    .empty       (empty),
    .vld_rd_data (vld_rd_data),
    .rd          (rd),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .count       (count),
    .flush_req   (flush_req),
    .flush_done  (flush_done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [31:0] expVld();
    return 32'((mq.size() > 0) && !mflush);
  endfunction

  function automatic logic [31:0] expData();
    if (expVld() == 0) return 32'h0;
    return (mq[0].data >> (4 * mcol)) & 32'hF;
  endfunction

  function automatic logic [31:0] expLast();
    if (expVld() == 0) return 32'h0;
    return 32'(mcol == mq[0].len);
  endfunction

  function automatic logic [31:0] expDone();
    return 32'(mflush && (mleft == 0));
  endfunction

  task automatic modelReset();
    mq.delete();
    mcol   = 0;
    mflush = 0;
    mleft  = 0;
  endtask

  // Advance the model by one clock edge using the inputs held in this cycle.
  task automatic modelEdge();
    bit acc;
    mword_t w;
    acc    = wr && (mq.size() < 4);
    w.data = wr_data;
    w.len  = int'(wr_nib);
    if (!mflush) begin
      if (rd && (expVld() != 0)) begin
        if (mcol == mq[0].len) begin
          void'(mq.pop_front());
          mcol = 0;
        end else begin
          mcol++;
        end
      end
      if (acc) mq.push_back(w);
      if (flush_req) begin
        mflush = 1;
        mleft  = mq.size();
      end
    end else begin
      if (mleft > 0) begin
        void'(mq.pop_front());
        mcol = 0;
        mleft--;
        if (acc) mq.push_back(w);
      end else begin
        if (acc) mq.push_back(w);
        mflush = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then step the model.
  task automatic applyStimulus(input bit w, input logic [31:0] d, input int n,
                               input bit r, input bit f);
    wr        = w;
    wr_data   = d;
    wr_nib    = 3'(n);
    rd        = r;
    flush_req = f;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Every falling edge, compare all outputs against the model's prediction.
  always @(negedge clk) begin
    checkOutput("empty",       32'(empty),       32'(mq.size() == 0));
    checkOutput("full",        32'(full),        32'(mq.size() == 4));
    checkOutput("count",       32'(count),       32'(mq.size()));
    checkOutput("vld_rd_data", 32'(vld_rd_data), expVld());
    checkOutput("rd_data",     32'(rd_data),     expData());
    checkOutput("rd_last",     32'(rd_last),     expLast());
    checkOutput("flush_done",  32'(flush_done),  expDone());
  end

  initial begin
    logic [31:0] words [4];
    int          edges;
    bit          fr;
    bit          cur_done;
    bit          w;
    bit          r;

    wr = 0; wr_data = '0; wr_nib = '0; rd = 0; flush_req = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_vld",   32'(vld_rd_data), 32'd0);
    checkOutput("rst_last",  32'(rd_last), 32'd0);

    $display("[TB] full word 0x87654321");
    applyStimulus(1, 32'h87654321, 7, 0, 0);
    checkOutput("fw_vld", 32'(vld_rd_data), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("fw_data", 32'(rd_data), 32'(i + 1));
      checkOutput("fw_last", 32'(rd_last), 32'(i == 7));
      applyStimulus(0, 32'h0, 0, 1, 0);
    end
    checkOutput("fw_empty", 32'(empty), 32'd1);

    $display("[TB] partial words");
    applyStimulus(1, 32'h000000AB, 1, 0, 0);
    applyStimulus(1, 32'hFFFFFFFC, 0, 0, 0);
    checkOutput("pw_count2", 32'(count), 32'd2);
    checkOutput("pw_b", 32'(rd_data), 32'hB);
    applyStimulus(0, 32'h0, 0, 1, 0);
    checkOutput("pw_a", 32'(rd_data), 32'hA);
    checkOutput("pw_a_last", 32'(rd_last), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 0);
    checkOutput("pw_count1", 32'(count), 32'd1);
    checkOutput("pw_c", 32'(rd_data), 32'hC);
    checkOutput("pw_c_last", 32'(rd_last), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 0);
    checkOutput("pw_count0", 32'(count), 32'd0);

    $display("[TB] fill, drain, wrap");
    words[0] = 32'h1234_5678;
    words[1] = 32'h9ABC_DEF0;
    words[2] = 32'h0F1E_2D3C;
    words[3] = 32'hA5A5_5A5A;
    for (int i = 0; i < 4; i++) applyStimulus(1, words[i], 7, 0, 0);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 8; i++) applyStimulus(0, 32'h0, 0, 1, 0);
    checkOutput("drain_full", 32'(full), 32'd0);
    checkOutput("drain_head", 32'(rd_data), 32'h0);
    applyStimulus(1, 32'h7654_3210, 3, 0, 0);
    checkOutput("wrap_count", 32'(count), 32'd4);
    edges = 0;
    while (mq.size() > 0 && edges < 100) begin
      applyStimulus(0, 32'h0, 0, expVld() != 0, 0);
      edges++;
    end
    checkOutput("wrap_drained", 32'(empty), 32'd1);

    $display("[TB] flush with concurrent writes");
    for (int i = 0; i < 3; i++) applyStimulus(1, words[i], 7, 0, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'hDEADBEEF, 7, 0, 1);
    checkOutput("fl_blocked", 32'(vld_rd_data), 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 1);
    checkOutput("fl_done_e1", 32'(flush_done), 32'd0);
    applyStimulus(1, 32'h11111111, 7, 0, 1);
    checkOutput("fl_done_e2", 32'(flush_done), 32'd0);
    edges = 2;
    while (edges < 10) begin
      applyStimulus(0, 32'h0, 0, 0, 1);
      edges++;
      checkOutput("fl_done_k", 32'(flush_done), 32'(edges == 4));
      if (flush_done) break;
    end
    checkOutput("fl_latency", 32'(edges), 32'd4);
    applyStimulus(0, 32'h0, 0, 0, 0);
    checkOutput("fl_vld", 32'(vld_rd_data), 32'd1);
    checkOutput("fl_count", 32'(count), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("fl_surv", 32'(rd_data), 32'h1);
      applyStimulus(0, 32'h0, 0, 1, 0);
    end
    checkOutput("fl_empty", 32'(empty), 32'd1);

    $display("[TB] empty flush");
    applyStimulus(0, 32'h0, 0, 0, 1);
    checkOutput("ef_done", 32'(flush_done), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 0);
    checkOutput("ef_idle", 32'(flush_done), 32'd0);

    $display("[TB] reset mid-flush");
    applyStimulus(1, words[0], 7, 0, 0);
    applyStimulus(1, words[1], 7, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 1);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("mr_empty", 32'(empty), 32'd1);
    checkOutput("mr_count", 32'(count), 32'd0);
    checkOutput("mr_done",  32'(flush_done), 32'd0);
    checkOutput("mr_vld",   32'(vld_rd_data), 32'd0);
    flush_req = 0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    applyStimulus(1, 32'h0000CAFE, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mr_last", 32'(rd_last), 32'(i == 3));
      applyStimulus(0, 32'h0, 0, 1, 0);
    end
    checkOutput("mr_after", 32'(empty), 32'd1);

    $display("[TB] randomized traffic");
    fr = 0;
    for (int c = 0; c < 2000; c++) begin
      w = (mq.size() < 4) && ($urandom_range(0, 2) != 0);
      r = (expVld() != 0) && ($urandom_range(0, 1) == 1);
      if (!fr && !mflush && ($urandom_range(0, 39) == 0)) fr = 1;
      cur_done = (expDone() != 0);
      applyStimulus(w, $urandom, int'($urandom_range(0, 7)), r, fr);
      if (cur_done) fr = 0;
    end
    edges = 0;
    while ((fr || mflush) && edges < 20) begin
      cur_done = (expDone() != 0);
      applyStimulus(0, 32'h0, 0, 0, fr);
      if (cur_done) fr = 0;
      edges++;
    end
    checkOutput("rnd_flush_settled", 32'(mflush), 32'd0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
